// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard controller for the rv32i 5-stage core. It drives every pipeline-register
// load enable and the ID/EX bubble mux. It handles:
//   - memory freeze
//   - flush
//   - programmable multi-cycle load-use bubbles
//   - a single-entry scoreboard for the fixed-latency mul/div unit
// It also keeps saturating per-reason stall counters.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs1_addr_i, rs2_addr_i        ID source register addresses
//   rs1_used_i, rs2_used_i        ID instruction actually reads the source
//   id_valid_i, id_is_muldiv_i    ID holds a real instruction / a mul/div
//   ex_valid_i, ex_is_load_i      EX holds a real instruction / a load
//   ex_is_muldiv_i, rd_ex_i       EX is a mul/div / EX destination
//   stall_pipeline_i              memory not ready, freeze everything
//   flush_i                       branch/jump redirect, squash IF/ID
//   load_*_o                      pipeline register enables (combinational)
//   ctrlmux_sel_o                 1 = inject NOP control word into ID/EX
//   cur_stall_o                   memory freeze active
//   stall_reason_o                0 none, 1 load-use, 2 mem, 3 md RAW, 4 md structural
//   lu/mem/md_stall_cnt_o         saturating per-reason stall cycle counters (registered)
module hazard_scoreboard_unit #(
    parameter int unsigned REG_W           = 5,
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MD_LATENCY      = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_addr_i,
    input  logic [REG_W-1:0] rs2_addr_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic             id_valid_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic             ex_is_muldiv_i,
    input  logic [REG_W-1:0] rd_ex_i,
    input  logic             id_is_muldiv_i,
    input  logic             stall_pipeline_i,
    input  logic             flush_i,
    output logic             load_pc_o,
    output logic             load_if_id_o,
    output logic             load_id_ex_o,
    output logic             load_ex_mem_o,
    output logic             load_mem_wr_o,
    output logic             ctrlmux_sel_o,
    output logic             cur_stall_o,
    output logic [2:0]       stall_reason_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] md_stall_cnt_o
);

    localparam int unsigned LU_CNT_W = 3;
    localparam int unsigned MD_CNT_W = 4;

    localparam logic [2:0] R_NONE      = 3'd0;
    localparam logic [2:0] R_LU        = 3'd1;
    localparam logic [2:0] R_MEM       = 3'd2;
    localparam logic [2:0] R_MD_RAW    = 3'd3;
    localparam logic [2:0] R_MD_STRUCT = 3'd4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LU_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic                md_busy_q, md_busy_d;
    logic [REG_W-1:0]    md_rd_q, md_rd_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic [CNT_W-1:0]    lu_stall_cnt_q, mem_stall_cnt_q, md_stall_cnt_q;

    logic                dep_ex_c;
    logic                dep_md_c;

    // ID instruction reads register r (x0 never creates a dependence)
    function automatic logic dep_on(
        input logic [REG_W-1:0] r,
        input logic             id_valid,
        input logic             rs1_used,
        input logic [REG_W-1:0] rs1_addr,
        input logic             rs2_used,
        input logic [REG_W-1:0] rs2_addr
    );
        return id_valid && (r != '0) &&
               ((rs1_used && (rs1_addr == r)) || (rs2_used && (rs2_addr == r)));
    endfunction

    assign dep_ex_c = dep_on(rd_ex_i, id_valid_i, rs1_used_i, rs1_addr_i, rs2_used_i, rs2_addr_i);
    assign dep_md_c = dep_on(md_rd_q, id_valid_i, rs1_used_i, rs1_addr_i, rs2_used_i, rs2_addr_i);

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lu_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            md_rd_q   <= '0;
            md_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            md_busy_q <= md_busy_d;
            md_rd_q   <= md_rd_d;
            md_cnt_q  <= md_cnt_d;
        end
    end

    // Next state and enables; freeze > flush > load-use > md RAW > md structural
    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        md_busy_d      = md_busy_q;
        md_rd_d        = md_rd_q;
        md_cnt_d       = md_cnt_q;
        load_pc_o      = 1'b1;
        load_if_id_o   = 1'b1;
        load_id_ex_o   = 1'b1;
        load_ex_mem_o  = 1'b1;
        load_mem_wr_o  = 1'b1;
        ctrlmux_sel_o  = 1'b0;
        cur_stall_o    = 1'b0;
        stall_reason_o = R_NONE;

        if (stall_pipeline_i) begin
            // Whole pipeline and all internal state hold
            load_pc_o      = 1'b0;
            load_if_id_o   = 1'b0;
            load_id_ex_o   = 1'b0;
            load_ex_mem_o  = 1'b0;
            load_mem_wr_o  = 1'b0;
            cur_stall_o    = 1'b1;
            stall_reason_o = R_MEM;
        end else begin
            // Scoreboard runs regardless of flush: the mul/div is older than the branch
            if (md_busy_q) begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                if (md_cnt_q <= MD_CNT_W'(1)) begin
                    md_busy_d = 1'b0;
                end
            end
            if (ex_valid_i && ex_is_muldiv_i && (rd_ex_i != '0)) begin
                md_busy_d = 1'b1;
                md_rd_d   = rd_ex_i;
                md_cnt_d  = MD_CNT_W'(MD_LATENCY - 1);
            end

            if (flush_i) begin
                state_d  = IDLE;
                lu_cnt_d = '0;
            end else if ((state_q == LU_WAIT) || (ex_valid_i && ex_is_load_i && dep_ex_c)) begin
                load_pc_o      = 1'b0;
                load_if_id_o   = 1'b0;
                ctrlmux_sel_o  = 1'b1;
                stall_reason_o = R_LU;
                if (state_q == IDLE) begin
                    // A single-cycle bubble never needs LU_WAIT residency
                    lu_cnt_d = LU_CNT_W'(LU_STALL_CYCLES - 1);
                    if (LU_STALL_CYCLES > 1) begin
                        state_d = LU_WAIT;
                    end
                end else begin
                    lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
                    if (lu_cnt_q <= LU_CNT_W'(1)) begin
                        state_d  = IDLE;
                        lu_cnt_d = '0;
                    end
                end
            end else if (md_busy_q && dep_md_c) begin
                load_pc_o      = 1'b0;
                load_if_id_o   = 1'b0;
                ctrlmux_sel_o  = 1'b1;
                stall_reason_o = R_MD_RAW;
            end else if (md_busy_q && id_valid_i && id_is_muldiv_i) begin
                load_pc_o      = 1'b0;
                load_if_id_o   = 1'b0;
                ctrlmux_sel_o  = 1'b1;
                stall_reason_o = R_MD_STRUCT;
            end
        end
    end

    // Saturating per-reason stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt_q  <= '0;
            mem_stall_cnt_q <= '0;
            md_stall_cnt_q  <= '0;
        end else begin
            if ((stall_reason_o == R_LU) && (lu_stall_cnt_q != '1)) begin
                lu_stall_cnt_q <= lu_stall_cnt_q + CNT_W'(1);
            end
            if ((stall_reason_o == R_MEM) && (mem_stall_cnt_q != '1)) begin
                mem_stall_cnt_q <= mem_stall_cnt_q + CNT_W'(1);
            end
            if (((stall_reason_o == R_MD_RAW) || (stall_reason_o == R_MD_STRUCT)) &&
                (md_stall_cnt_q != '1)) begin
                md_stall_cnt_q <= md_stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign lu_stall_cnt_o  = lu_stall_cnt_q;
    assign mem_stall_cnt_o = mem_stall_cnt_q;
    assign md_stall_cnt_o  = md_stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. There are two instances:
//   u_a  LU_STALL_CYCLES=1, CNT_W=32
//   u_b  LU_STALL_CYCLES=3, CNT_W=2 (narrow counters, so saturation is reachable)
// Both share the same stimulus. Expected output words are queued when stimulus
// is applied and popped and compared just after the inputs settle.
module tb_hazard_scoreboard_unit;

    localparam int unsigned REG_W = 5;

    typedef struct {
        bit         sel_b;
        logic [9:0] v;
        string      tag;
    } exp_t;

    localparam logic [9:0] DEF = 10'b11111_0_0_000;
    localparam logic [9:0] MEM = 10'b00000_0_1_010;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] rs1_addr, rs2_addr, rd_ex;
    logic             rs1_used, rs2_used, id_valid, ex_valid, ex_is_load, ex_is_muldiv;
    logic             id_is_muldiv, stall_pipeline, flush;

    logic        a_pc, a_ifid, a_idex, a_exmem, a_memwr, a_mux, a_cur;
    logic [2:0]  a_rsn;
    logic [31:0] a_lu, a_mem, a_md;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_memwr, b_mux, b_cur;
    logic [2:0]  b_rsn;
    logic [1:0]  b_lu, b_mem, b_md;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_W(REG_W), .LU_STALL_CYCLES(1), .MD_LATENCY(4), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .id_valid_i(id_valid), .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load),
        .ex_is_muldiv_i(ex_is_muldiv), .rd_ex_i(rd_ex), .id_is_muldiv_i(id_is_muldiv),
        .stall_pipeline_i(stall_pipeline), .flush_i(flush),
        .load_pc_o(a_pc), .load_if_id_o(a_ifid), .load_id_ex_o(a_idex), .load_ex_mem_o(a_exmem),
        .load_mem_wr_o(a_memwr), .ctrlmux_sel_o(a_mux), .cur_stall_o(a_cur), .stall_reason_o(a_rsn),
        .lu_stall_cnt_o(a_lu), .mem_stall_cnt_o(a_mem), .md_stall_cnt_o(a_md)
    );

    hazard_scoreboard_unit #(.REG_W(REG_W), .LU_STALL_CYCLES(3), .MD_LATENCY(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .id_valid_i(id_valid), .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load),
        .ex_is_muldiv_i(ex_is_muldiv), .rd_ex_i(rd_ex), .id_is_muldiv_i(id_is_muldiv),
        .stall_pipeline_i(stall_pipeline), .flush_i(flush),
        .load_pc_o(b_pc), .load_if_id_o(b_ifid), .load_id_ex_o(b_idex), .load_ex_mem_o(b_exmem),
        .load_mem_wr_o(b_memwr), .ctrlmux_sel_o(b_mux), .cur_stall_o(b_cur), .stall_reason_o(b_rsn),
        .lu_stall_cnt_o(b_lu), .mem_stall_cnt_o(b_mem), .md_stall_cnt_o(b_md)
    );

    function automatic logic [9:0] bub(input logic [2:0] r);
        return {5'b00111, 1'b1, 1'b0, r};
    endfunction

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic md);
        id_valid = v; rs1_addr = r1; rs1_used = u1; rs2_addr = r2; rs2_used = u2; id_is_muldiv = md;
    endtask

    task automatic set_ex(input logic v, input logic ld, input logic md, input logic [4:0] rd);
        ex_valid = v; ex_is_load = ld; ex_is_muldiv = md; rd_ex = rd;
    endtask

    task automatic expect_out(input bit sel_b, input logic [9:0] v, input string tag);
        exp_t e;
        e.sel_b = sel_b; e.v = v; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Compare every queued expectation against the settled outputs, then advance one cycle
    task automatic cyc();
        exp_t       e;
        logic [9:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = e.sel_b ? {b_pc, b_ifid, b_idex, b_exmem, b_memwr, b_mux, b_cur, b_rsn}
                          : {a_pc, a_ifid, a_idex, a_exmem, a_memwr, a_mux, a_cur, a_rsn};
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_cnt(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_ex(1'b0, 1'b0, 1'b0, 5'd0);
        stall_pipeline = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state: defaults and zeroed counters
        expect_out(1'b0, DEF, "reset_a");
        expect_out(1'b1, DEF, "reset_b");
        cyc();
        check_cnt(a_lu, 32'd0, "reset_lu_cnt_a");
        check_cnt(32'(b_md), 32'd0, "reset_md_cnt_b");

        // Load-use, single bubble: EX lw x5, ID add x6,x5,x1
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
        expect_out(1'b0, bub(3'd1), "lu1_bubble");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0);
        expect_out(1'b0, DEF, "lu1_release");
        cyc();
        check_cnt(a_lu, 32'd1, "lu1_cnt");

        // Load-use, three bubbles
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
        expect_out(1'b1, bub(3'd1), "lu3_bubble1");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0);
        expect_out(1'b1, bub(3'd1), "lu3_bubble2");
        cyc();
        expect_out(1'b1, bub(3'd1), "lu3_bubble3");
        cyc();
        expect_out(1'b1, DEF, "lu3_release");
        cyc();
        check_cnt(32'(b_lu), 32'd3, "lu3_cnt");

        // rd_ex = x0 and an unused rs2 match never stall
        set_ex(1'b1, 1'b1, 1'b0, 5'd0); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        expect_out(1'b0, DEF, "lu_x0_a");
        expect_out(1'b1, DEF, "lu_x0_b");
        cyc();
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        expect_out(1'b0, DEF, "lu_rs2_unused_a");
        expect_out(1'b1, DEF, "lu_rs2_unused_b");
        cyc();

        // Muldiv RAW: mul x7 issues, dependent add x8,x7 waits three cycles
        do_reset();
        set_ex(1'b1, 1'b0, 1'b1, 5'd7); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1'b0, DEF, "md_raw_issue");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_out(1'b0, bub(3'd3), "md_raw_bubble");
            cyc();
        end
        expect_out(1'b0, DEF, "md_raw_release");
        cyc();
        check_cnt(a_md, 32'd3, "md_raw_cnt");

        // Muldiv structural: mul x9 held behind mul x7
        set_ex(1'b1, 1'b0, 1'b1, 5'd7); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1'b0, DEF, "md_st_issue");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_out(1'b0, bub(3'd4), "md_st_bubble");
            cyc();
        end
        expect_out(1'b0, DEF, "md_st_release");
        cyc();
        check_cnt(a_md, 32'd6, "md_st_cnt");

        // Memory freeze inside LU_WAIT, then mem counter saturation (2-bit)
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
        expect_out(1'b1, bub(3'd1), "frz_bubble1");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); stall_pipeline = 1'b1;
        expect_out(1'b1, MEM, "frz_mem1");
        cyc();
        expect_out(1'b1, MEM, "frz_mem2");
        cyc();
        check_cnt(32'(b_mem), 32'd2, "frz_mem_cnt");
        stall_pipeline = 1'b0;
        expect_out(1'b1, bub(3'd1), "frz_bubble2");
        cyc();
        expect_out(1'b1, bub(3'd1), "frz_bubble3");
        cyc();
        expect_out(1'b1, DEF, "frz_release");
        cyc();
        check_cnt(32'(b_lu), 32'd3, "frz_lu_cnt");
        stall_pipeline = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out(1'b1, MEM, "sat_mem");
            cyc();
        end
        stall_pipeline = 1'b0;
        check_cnt(32'(b_mem), 32'd3, "sat_mem_cnt");

        // Flush during LU_WAIT ends the bubbles; flush also masks a fresh hazard
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
        expect_out(1'b1, bub(3'd1), "fl_bubble1");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); flush = 1'b1;
        expect_out(1'b1, DEF, "fl_flush");
        cyc();
        flush = 1'b0; set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1'b1, DEF, "fl_after");
        cyc();
        set_ex(1'b1, 1'b1, 1'b0, 5'd5); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0); flush = 1'b1;
        expect_out(1'b1, DEF, "fl_masks_hazard");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); flush = 1'b0;
        expect_out(1'b1, DEF, "fl_stays_idle");
        cyc();

        // Reset mid-muldiv: scoreboard cleared, dependent proceeds at once
        do_reset();
        set_ex(1'b1, 1'b0, 1'b1, 5'd7); set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out(1'b0, DEF, "rmd_issue");
        cyc();
        set_ex(1'b0, 1'b0, 1'b0, 5'd0); set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out(1'b0, bub(3'd3), "rmd_bubble");
        cyc();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_out(1'b0, DEF, "rmd_release");
        cyc();
        check_cnt(a_md, 32'd0, "rmd_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
